// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port (IF) and the data port (MEM) onto one shared memory, MEM has fixed priority.
// Define MEM_ARB_STATS_EN to build the saturating conflict counter; otherwise Conflict_Count is tied to 0.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1  // memory access latency, legal range 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_Req,
    input  logic [15:0] IF_Addr,
    output logic        IF_Ready,
    output logic [15:0] IF_RData,
    input  logic        MEM_Req,
    input  logic        MEM_We,
    input  logic [15:0] MEM_Addr,
    input  logic [15:0] MEM_WData,
    output logic        MEM_Ready,
    output logic [15:0] MEM_RData,
    output logic        Stall_Out,
    output logic        Mem_En,
    output logic        Mem_We,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_WData,
    input  logic [15:0] Mem_RData,
    output logic [15:0] Conflict_Count,
    output logic [1:0]  dbg_state_o
);

    // Handshake: Req is a level held by the requester until it sees its one-cycle Ready pulse.
    // A Req seen in that requester's own Ready cycle is ignored, so a still-held Req does not
    // retrigger; Addr/We/WData are captured only in the grant cycle and ignored until Ready.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;

    logic        if_elig;
    logic        mem_elig;
    logic        busy;

    assign if_elig  = IF_Req & ~if_ready_q;
    assign mem_elig = MEM_Req & ~mem_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_elig) begin
                    state_d = BUSY_MEM;
                    cnt_d   = CNT_LOAD;
                    addr_d  = MEM_Addr;
                    wdata_d = MEM_WData;
                    we_d    = MEM_We;
                end else if (if_elig) begin
                    state_d = BUSY_IF;
                    cnt_d   = CNT_LOAD;
                    addr_d  = IF_Addr;
                    wdata_d = 16'h0000;
                    we_d    = 1'b0;
                end
            end
            BUSY_IF: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d    = IDLE;
                    if_ready_d = 1'b1;
                    if_rdata_d = Mem_RData;
                end
            end
            BUSY_MEM: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d     = IDLE;
                    mem_ready_d = 1'b1;
                    // A store leaves the last loaded word visible.
                    if (!we_q) begin
                        mem_rdata_d = Mem_RData;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign Mem_En    = busy;
    assign Mem_We    = (state_q == BUSY_MEM) & we_q;
    assign Mem_Addr  = busy ? addr_q : 16'h0000;
    assign Mem_WData = busy ? wdata_q : 16'h0000;

    assign IF_Ready  = if_ready_q;
    assign IF_RData  = if_rdata_q;
    assign MEM_Ready = mem_ready_q;
    assign MEM_RData = mem_rdata_q;

    // Held low during reset so every output reads 0 while rst is asserted.
    assign Stall_Out = ~rst & ((IF_Req & ~if_ready_q) | (MEM_Req & ~mem_ready_q));

    assign dbg_state_o = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if ((state_q == IDLE) && if_elig && mem_elig && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= 16'h0000;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign Conflict_Count = conflict_cnt_q;
`else
    assign Conflict_Count = 16'h0000;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, memory access latency in cycles, legal range 1..7.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 IF_Req  input  1  fetch-stage read request.
REQ-005 IF_Addr  input  16  fetch address.
REQ-006 IF_Ready  output  1  one-cycle pulse, fetch complete.
REQ-007 IF_RData  output  16  fetched word, registered.
REQ-008 MEM_Req  input  1  memory-stage request.
REQ-009 MEM_We  input  1  1 = write, 0 = read.
REQ-010 MEM_Addr  input  16  data address.
REQ-011 MEM_WData  input  16  store data.
REQ-012 MEM_Ready  output  1  one-cycle pulse, data access complete.
REQ-013 MEM_RData  output  16  loaded word, registered.
REQ-014 Stall_Out  output  1  pipeline stall request.
REQ-015 Mem_En, Mem_We  output  1 each  shared memory enable and write strobe.
REQ-016 Mem_Addr, Mem_WData  output  16 each  shared memory address and write data.
REQ-017 Mem_RData  input  16  shared memory read data.
REQ-018 Conflict_Count  output  16  arbitration-conflict counter (see Configuration).

Function
REQ-019 FSM states SHALL be IDLE, BUSY_IF and BUSY_MEM, with a 3-bit down-counter cnt.
REQ-020 In IDLE, an eligible MEM_Req SHALL win over an eligible IF_Req (fixed MEM priority); winner -> BUSY_x; cnt <= WAIT_CYCLES-1.
REQ-021 A requester is eligible when its Req=1 and its Ready=0 in that cycle; a Req seen during the requester's own Ready cycle SHALL be ignored.
REQ-022 On grant, the arbiter SHALL latch Addr, We and WData; input changes before the matching Ready SHALL be ignored.
REQ-023 In BUSY_x, Mem_En=1 and Mem_Addr/Mem_WData SHALL equal the latched values; Mem_We = latched We in BUSY_MEM and 0 in BUSY_IF.
REQ-024 In IDLE, Mem_En, Mem_We, Mem_Addr and Mem_WData SHALL be 0.
REQ-025 In BUSY_x, cnt SHALL decrement when nonzero; when cnt=0: state <= IDLE, x_Ready <= 1 for exactly one cycle.
REQ-026 On a read, x_RData <= Mem_RData, sampled in the cnt=0 cycle; on a write, MEM_RData SHALL hold its previous value.
REQ-027 Request-to-Ready latency SHALL be WAIT_CYCLES+1 cycles when uncontended.
REQ-028 The Ready cycle is an IDLE cycle: the other requester may be granted in it, so back-to-back transactions have no gap.
REQ-029 Stall_Out = (IF_Req & ~IF_Ready) | (MEM_Req & ~MEM_Ready), combinational.

Reset
REQ-030 While rst=1: state=IDLE, cnt=0, latched registers=0, and all outputs SHALL be 0.
REQ-031 Reset during BUSY_x SHALL drop Mem_En immediately, with no Ready issued for the aborted access.
REQ-032 After reset, a still-asserted request SHALL be re-arbitrated from IDLE.

Configuration
REQ-033 Macro MEM_ARB_STATS_EN defined: Conflict_Count increments each IDLE cycle in which both requesters are eligible, saturates at 0xFFFF, and is cleared by rst.
REQ-034 Macro MEM_ARB_STATS_EN undefined: the Conflict_Count port SHALL remain present, be tied to 0, and have no counter logic.

Verification (WAIT_CYCLES=2, MEM_ARB_STATS_EN defined unless noted)
REQ-035 Reset: rst=1 during BUSY_MEM -> Mem_En=0 the same cycle; all outputs 0; no MEM_Ready.
REQ-036 Lone fetch: IF_Req=1, IF_Addr=0x0010, Mem_RData=0xABCD at cycle 0 -> Mem_En=1 with Mem_Addr=0x0010 in cycles 1-2; IF_Ready=1 with IF_RData=0xABCD in cycle 3.
REQ-037 Contention at cycle 0 (IF_Req=1; MEM_Req=1 with We=1, Addr=0x0200, WData=0x1234):
- Mem_We=1 in cycles 1-2.
- MEM_Ready in cycle 3; IF is granted in cycle 3.
- IF_Ready in cycle 6.
- Stall_Out=1 in cycles 0-5, then 0.
- Conflict_Count=1.
REQ-038 Address change: MEM_Addr changes 0x0200->0x0300 during BUSY_MEM -> Mem_Addr stays 0x0200 until MEM_Ready.
REQ-039 Stats saturation: 65540 consecutive conflict IDLE cycles (forced) -> Conflict_Count=0xFFFF; with the macro undefined, Conflict_Count=0 throughout REQ-037.
